// File: rtl/cart_sram_backup_pkg.sv
// cart_sram_backup_pkg
// Shared definitions for the cartridge SRAM backup path: the upload read
// FSM state encoding, the byte returned for unmapped reads, and the Game
// Master 2 SRAM address width (8 KB).
package cart_sram_backup_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        LAT  = 2'd2,
        DATA = 2'd3
    } cart_rd_state_t;

    localparam logic [7:0] SRAM_FILL   = 8'hFF;
    localparam int         GM2_SRAM_AW = 13;

endpackage

// File: rtl/cart_sram_idle_timer.sv
// cart_sram_idle_timer
// Autosave idle counter. It counts clk cycles since the last CPU SRAM write
// while the SRAM is dirty and no upload session is active. When the count
// reaches IDLE_CYCLES-1 it issues a single save_request pulse and then holds
// until the next CPU write restarts it.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   cpu_sram_we  in   CPU write strobe (clears the counter)
//   upload_req   in   upload session active (freezes the counter)
//   dirty        in   SRAM modified since the last completed save
//   save_request out  one-cycle autosave pulse
module cart_sram_idle_timer #(
    parameter logic [23:0] IDLE_CYCLES = 24'd3_580_000
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_sram_we,
    input  logic upload_req,
    input  logic dirty,
    output logic save_request
);

    localparam logic [23:0] LIMIT = IDLE_CYCLES - 24'd1;

    logic [23:0] r_count;
    logic        r_pulse;
    logic [23:0] w_count_inc;

    assign w_count_inc = r_count + 24'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_pulse <= 1'b0;
        end else if (cpu_sram_we) begin
            r_count <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            // The pulse fires only on the step that lands on LIMIT; once
            // there the counter stops, so no repeat until a new write.
            if (!upload_req && dirty && (r_count < LIMIT)) begin
                r_count <= w_count_inc;
                r_pulse <= (w_count_inc == LIMIT);
            end
        end
    end

    assign save_request = r_pulse;

endmodule

// File: rtl/cart_sram_backup.sv
// cart_sram_backup
// Streams battery-backed cartridge SRAM back to the host over the ioctl
// upload channel, one byte per host read strobe, and tracks whether the
// SRAM has been written since the last complete dump.
//
// Optional feature: define CART_SRAM_AUTOSAVE_EN to build the idle timer
// that requests an autosave IDLE_CYCLES after the last CPU write. Without
// it, save_request is tied low.
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   cpu_sram_we    CPU write strobe into cart SRAM
//   upload_req     host upload session active (level)
//   upload_rd      host byte-read strobe
//   upload_addr    25-bit byte address of the host read
//   upload_dout    byte returned to the host (0xFF for unmapped reads)
//   upload_wait    host holds off while high
//   mem_sel        this block owns the SRAM address port
//   mem_addr       SRAM read address
//   mem_q          SRAM read data, one-cycle registered latency
//   save_pending   SRAM dirty since the last completed save
//   save_request   one-cycle autosave pulse
module cart_sram_backup
    import cart_sram_backup_pkg::*;
#(
    parameter int          ADDR_WIDTH  = GM2_SRAM_AW,
    parameter logic [23:0] IDLE_CYCLES = 24'd3_580_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_sram_we,
    input  logic                  upload_req,
    input  logic                  upload_rd,
    input  logic [24:0]           upload_addr,
    output logic [7:0]            upload_dout,
    output logic                  upload_wait,
    output logic                  mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_q,
    output logic                  save_pending,
    output logic                  save_request
);

    cart_rd_state_t        r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [7:0]            r_dout, w_dout_nxt;
    logic                  r_wait, w_wait_nxt;
    logic                  r_sel, w_sel_nxt;

    logic r_dirty, r_rewrite, r_last_seen, r_req_d;
    logic w_in_range, w_rd_ok, w_rd_last, w_req_fall;

    assign w_in_range = ~|upload_addr[24:ADDR_WIDTH];
    assign w_rd_ok    = upload_rd & upload_req;
    assign w_rd_last  = w_rd_ok && w_in_range && (r_state == IDLE)
                        && (&upload_addr[ADDR_WIDTH-1:0]);
    assign w_req_fall = r_req_d & ~upload_req;

    // Read FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mem_addr <= '0;
            r_dout     <= SRAM_FILL;
            r_wait     <= 1'b0;
            r_sel      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_dout     <= w_dout_nxt;
            r_wait     <= w_wait_nxt;
            r_sel      <= w_sel_nxt;
        end
    end

    // Read FSM: next state and registered outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_mem_addr_nxt = r_mem_addr;
        w_dout_nxt     = r_dout;
        w_wait_nxt     = r_wait;
        w_sel_nxt      = r_sel;
        unique case (r_state)
            IDLE: begin
                // An unmapped read holds wait for just the one cycle after
                // the strobe; this default drops it again.
                w_wait_nxt = 1'b0;
                if (w_rd_ok) begin
                    w_wait_nxt = 1'b1;
                    if (w_in_range) begin
                        w_mem_addr_nxt = upload_addr[ADDR_WIDTH-1:0];
                        w_sel_nxt      = 1'b1;
                        w_state_nxt    = ADDR;
                    end else begin
                        w_dout_nxt = SRAM_FILL;
                    end
                end
            end
            // Address is on the SRAM port; its registered read lands next cycle
            ADDR: w_state_nxt = LAT;
            LAT: begin
                w_dout_nxt  = mem_q;
                w_state_nxt = DATA;
            end
            DATA: begin
                w_wait_nxt  = 1'b0;
                w_sel_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Dirty tracking. A save only counts as complete if the session read the
    // last byte and no CPU write raced the dump; a write on the closing edge
    // still wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dirty     <= 1'b0;
            r_rewrite   <= 1'b0;
            r_last_seen <= 1'b0;
            r_req_d     <= 1'b0;
        end else begin
            r_req_d <= upload_req;
            if (cpu_sram_we)
                r_dirty <= 1'b1;
            else if (w_req_fall && r_last_seen && !r_rewrite)
                r_dirty <= 1'b0;
            if (w_req_fall) begin
                r_rewrite   <= 1'b0;
                r_last_seen <= 1'b0;
            end else begin
                if (cpu_sram_we && upload_req)
                    r_rewrite <= 1'b1;
                if (w_rd_last)
                    r_last_seen <= 1'b1;
            end
        end
    end

    assign upload_dout  = r_dout;
    assign upload_wait  = r_wait;
    assign mem_sel      = r_sel;
    assign mem_addr     = r_mem_addr;
    assign save_pending = r_dirty;

`ifdef CART_SRAM_AUTOSAVE_EN
    cart_sram_idle_timer #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_idle_timer (
        .clk          (clk),
        .reset        (reset),
        .cpu_sram_we  (cpu_sram_we),
        .upload_req   (upload_req),
        .dirty        (r_dirty),
        .save_request (save_request)
    );
`else
    logic w_unused_idle;
    assign w_unused_idle = ^IDLE_CYCLES;
    assign save_request  = 1'b0;
`endif

endmodule
